// File: rtl/microcode_seq.sv
// Host-loadable microcode store and sequencer: runs gate programs from a shared
// instruction RAM, with single-level hardware loops, abort and error reporting.
module microcode_seq #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NUM_PROGS = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  output logic          cfg_reject,
  input  logic          start,
  input  logic [PW-1:0] prog_id,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr_data,
  output logic [AW-1:0] instr_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] OP_LOOP = 4'hE;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] base_tab [NUM_PROGS];
  logic [31:0]   rdata;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    loop_cnt_q, loop_cnt_d;
  logic          loop_active_q, loop_active_d;
  logic          err_d, valid_d;
  logic [31:0]   data_d;
  logic [AW-1:0] ipc_d;
  logic [AW:0]   nxt;

  logic [3:0]    op;
  logic [7:0]    lp_n, lp_t;
  logic [AW:0]   pc_inc, tgt;

  assign op     = rdata[31:28];
  assign lp_n   = rdata[19:12];
  assign lp_t   = rdata[11:4];
  // One bit wider than the RAM address so running off the end is detectable.
  assign pc_inc = (AW+1)'(pc_q) + (AW+1)'(1);
  assign tgt    = (AW+1)'(base_q) + (AW+1)'(lp_t);

  // Instruction RAM: host writes only while idle, registered read at pc.
  always_ff @(posedge clk) begin : ram_port
    if (cfg_we && !cfg_sel && state_q == S_IDLE) begin
      ram[cfg_addr] <= cfg_wdata;
    end
    rdata <= ram[pc_q];
  end

  // Next-state and next-output decisions.
  always_comb begin : next_state
    state_d       = state_q;
    pc_d          = pc_q;
    base_d        = base_q;
    loop_cnt_d    = loop_cnt_q;
    loop_active_d = loop_active_q;
    err_d         = err;
    valid_d       = instr_valid;
    data_d        = instr_data;
    ipc_d         = instr_pc;
    nxt           = pc_inc;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d        = base_tab[prog_id];
          pc_d          = base_tab[prog_id];
          loop_active_d = 1'b0;
          err_d         = 1'b0;
          state_d       = S_FETCH;
          if (32'(prog_id) >= NUM_PROGS) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_END) begin
          state_d = S_DONE;
        end else if (op == OP_LOOP) begin
          state_d = S_FETCH;
          if (!loop_active_q && lp_n != 8'd0) begin
            loop_cnt_d    = lp_n;
            loop_active_d = 1'b1;
            nxt           = tgt;
          end else if (loop_active_q && loop_cnt_q > 8'd1) begin
            loop_cnt_d = loop_cnt_q - 8'd1;
            nxt        = tgt;
          end else begin
            loop_active_d = 1'b0;
            nxt           = pc_inc;
          end
          if (nxt >= DEPTH_W) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d = nxt[AW-1:0];
          end
        end else begin
          valid_d = 1'b1;
          data_d  = rdata;
          ipc_d   = pc_q;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (pc_inc >= DEPTH_W) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_inc[AW-1:0];
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything decided above and leaves err as it was.
    if (abort && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      valid_d       = 1'b0;
      loop_active_d = 1'b0;
      err_d         = err;
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      base_q        <= '0;
      loop_cnt_q    <= '0;
      loop_active_q <= 1'b0;
      err           <= 1'b0;
      instr_valid   <= 1'b0;
      instr_data    <= '0;
      instr_pc      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_reject    <= 1'b0;
      base_tab      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      base_q        <= base_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_active_q <= loop_active_d;
      err           <= err_d;
      instr_valid   <= valid_d;
      instr_data    <= data_d;
      instr_pc      <= ipc_d;
      busy          <= (state_d != S_IDLE);
      done          <= (state_d == S_DONE);
      cfg_reject    <= cfg_we && (state_q != S_IDLE);
      if (cfg_we && cfg_sel && state_q == S_IDLE) begin
        base_tab[cfg_addr[PW-1:0]] <= cfg_wdata[AW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_microcode_seq.sv
// Randomized and directed bench for microcode_seq, checked against a
// program-level reference model of the sequencer's fetch/loop/emit rules.
module tb_microcode_seq;
  localparam int DEPTH     = 256;
  localparam int NUM_PROGS = 8;
  localparam int AW        = 8;
  localparam int PW        = 3;

  logic          clk = 1'b0;
  logic          rst_n, cfg_we, cfg_sel, start, abort, instr_ready;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [PW-1:0] prog_id;
  logic          cfg_reject, busy, done, err, instr_valid;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_pc;

  always #5 clk = ~clk;

  microcode_seq #(.DEPTH(DEPTH), .NUM_PROGS(NUM_PROGS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_reject(cfg_reject),
    .start(start), .prog_id(prog_id), .abort(abort), .busy(busy),
    .done(done), .err(err), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] mram [DEPTH];
  int          mbase [NUM_PROGS];
  int          exp_pc[$];
  logic [31:0] exp_data[$];
  int          exp_err, exp_t;

  // Observation state
  int          cyc = 0, done_cnt = 0, done_cyc = 0, rej_cnt = 0;
  int          first_v_cyc = -1, stall_seen = 0, stall_cnt = 0, ready_mode = 0;
  int          got_pc[$];
  logic [31:0] got_data[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [AW-1:0] prev_pc;
  int          start_cyc, d0;

  // Walks the program as the sequencer should; exp_t is the edge index
  // (counting the start edge as 0) after which done is high, ready held high.
  task automatic model_run(input int prog);
    int pc, b, cnt, nxt;
    bit act;
    logic [31:0] w;
    exp_pc.delete(); exp_data.delete();
    exp_err = 0; exp_t = 0;
    b = mbase[prog]; pc = b; act = 1'b0; cnt = 0;
    for (int s = 0; s < 4000; s++) begin
      w = mram[pc];
      exp_t += 2;
      if (w[31:28] == 4'hF) break;
      if (w[31:28] == 4'hE) begin
        int n, t;
        n = int'(w[19:12]);
        t = int'(w[11:4]);
        if (!act && n != 0) begin cnt = n; act = 1'b1; nxt = b + t; end
        else if (act && cnt > 1) begin cnt = cnt - 1; nxt = b + t; end
        else begin act = 1'b0; nxt = pc + 1; end
      end else begin
        exp_pc.push_back(pc);
        exp_data.push_back(w);
        exp_t += 1;
        nxt = pc + 1;
      end
      if (nxt >= DEPTH) begin exp_err = 1; break; end
      pc = nxt;
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: instr_ready = 1'b1;
      1: instr_ready = 1'($urandom_range(0, 1));
      2: instr_ready = 1'b0;
      default: begin
        if (instr_valid && stall_cnt < 5) begin instr_ready = 1'b0; stall_cnt++; end
        else instr_ready = 1'b1;
      end
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (prev_stall) begin
      check("hold_valid", instr_valid, 1);
      check("hold_data", instr_data, prev_data);
      check("hold_pc", instr_pc, prev_pc);
    end
    if (instr_valid && instr_ready && rst_n && !abort) begin
      got_pc.push_back(int'(instr_pc));
      got_data.push_back(instr_data);
    end
    if (instr_valid && !instr_ready) stall_seen++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_reject) rej_cnt++;
    if (instr_valid && first_v_cyc < 0) first_v_cyc = cyc;
    prev_stall = instr_valid && !instr_ready && rst_n && !abort;
    prev_data  = instr_data;
    prev_pc    = instr_pc;
  end

  task automatic wr_ram(input int a, input logic [31:0] d, input bit idle);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(a); cfg_wdata = d;
    @(posedge clk); #1 cfg_we = 1'b0;
    if (idle) mram[a] = d;
  endtask

  task automatic wr_base(input int slot, input int v);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = AW'(slot); cfg_wdata = 32'(v);
    @(posedge clk); #1 cfg_we = 1'b0;
    mbase[slot] = v;
  endtask

  task automatic begin_run(input int prog, input int mode);
    model_run(prog);
    got_pc.delete(); got_data.delete();
    first_v_cyc = -1; ready_mode = mode; stall_cnt = 0; stall_seen = 0; d0 = done_cnt;
    prog_id = PW'(prog); start = 1'b1;
    @(posedge clk); start_cyc = cyc; #1 start = 1'b0;
    @(negedge clk);
    check("busy_on_start", busy, 1);
    check("err_cleared", err, 0);
    @(posedge clk); #1;
  endtask

  task automatic finish_run(input bit timing);
    int nmin;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    #1;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_pulse_end", done, 0);
    check("done_count", done_cnt, d0 + 1);
    check("emit_count", got_pc.size(), exp_pc.size());
    nmin = (got_pc.size() < exp_pc.size()) ? got_pc.size() : exp_pc.size();
    for (int k = 0; k < nmin; k++) begin
      check("emit_pc", got_pc[k], exp_pc[k]);
      check("emit_data", got_data[k], exp_data[k]);
    end
    check("err_flag", err, exp_err);
    if (timing) begin
      check("done_latency", done_cyc - start_cyc - 1, exp_t);
      if (exp_pc.size() > 0) check("first_valid", first_v_cyc - start_cyc - 1, 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !instr_valid; i++) begin @(posedge clk); #1; end
    check("valid_seen", instr_valid, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, instr_valid, 0);
  endtask

  int r0;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; prog_id = '0; abort = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mram[i] = 32'h0;
    for (int i = 0; i < NUM_PROGS; i++) mbase[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_reject", cfg_reject, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_data", instr_data, 0);
    check("rst_pc", instr_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Bell program
    wr_ram(0, 32'hF000_0000, 1);
    wr_base(3, 'h10);
    wr_ram('h10, 32'h1000_0000, 1);
    wr_ram('h11, 32'h4100_0000, 1);
    wr_ram('h12, 32'hF000_0000, 1);
    begin_run(3, 0); finish_run(1);

    // Backpressure on the first word
    begin_run(3, 3); finish_run(0);
    check("stall_cycles", stall_seen, 5);

    // Loop N=2 and N=0
    wr_base(1, 'h20);
    wr_ram('h20, 32'h1000_0000, 1);
    wr_ram('h21, 32'hE000_2000, 1);
    wr_ram('h22, 32'hF000_0000, 1);
    begin_run(1, 0); finish_run(1);
    wr_base(2, 'h30);
    wr_ram('h30, 32'h1000_0000, 1);
    wr_ram('h31, 32'hE000_0000, 1);
    wr_ram('h32, 32'hF000_0000, 1);
    begin_run(2, 0); finish_run(1);

    // Overflow off the top of RAM, then a clean run clears err
    wr_base(4, DEPTH - 2);
    wr_ram(DEPTH - 2, 32'h2000_0000, 1);
    wr_ram(DEPTH - 1, 32'h3000_0000, 1);
    begin_run(4, 0); finish_run(1);
    begin_run(3, 0); finish_run(1);

    // Write while busy is rejected; same write while idle lands
    r0 = rej_cnt;
    begin_run(3, 2); wait_valid();
    wr_ram('h11, 32'h5A5A_5A50, 0);
    @(negedge clk); check("reject_pulse", cfg_reject, 1);
    @(posedge clk); #1 ready_mode = 0;
    finish_run(0);
    check("reject_count", rej_cnt, r0 + 1);
    r0 = rej_cnt;
    wr_ram('h11, 32'h2000_0000, 1);
    @(negedge clk); check("no_reject_idle", cfg_reject, 0);
    @(posedge clk); #1;
    begin_run(3, 0); finish_run(1);
    check("reject_idle_count", rej_cnt, r0);

    // Abort mid-EMIT
    begin_run(3, 2); wait_valid();
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); check_idle("abort");
    repeat (4) @(posedge clk); #1;
    check("abort_no_done", done_cnt, d0);
    check("abort_err", err, 0);
    begin_run(3, 0); finish_run(1);

    // Reset mid-loop, then the base table is clear and the loop reruns fully
    begin_run(1, 0);
    for (int i = 0; i < 100 && got_pc.size() < 2; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < NUM_PROGS; i++) mbase[i] = 0;
    @(negedge clk);
    check_idle("reset");
    check("reset_data", instr_data, 0);
    check("reset_pc", instr_pc, 0);
    repeat (3) @(posedge clk); #1;
    check("reset_no_done", done_cnt, d0);
    begin_run(1, 0); finish_run(1);
    wr_base(1, 'h20);
    begin_run(1, 0); finish_run(1);

    // Random programs under random backpressure
    repeat (20) begin
      int slot, b, len, lp;
      logic [31:0] w;
      slot = $urandom_range(0, NUM_PROGS - 1);
      b    = $urandom_range(0, DEPTH - 16);
      len  = $urandom_range(1, 8);
      lp   = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : -1;
      for (int j = 0; j < len; j++) begin
        if (j == lp) w = {4'hE, 8'h00, 8'($urandom_range(0, 3)), 8'($urandom_range(0, j - 1)), 4'h0};
        else w = {4'($urandom_range(0, 6)), 4'($urandom), 4'($urandom), 16'($urandom), 4'h0};
        wr_ram(b + j, w, 1);
      end
      wr_ram(b + len, 32'hF000_0000, 1);
      wr_base(slot, b);
      begin_run(slot, 1); finish_run(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
